// File: rtl/miriscv_mem_arbiter.sv
// Shares the single-port miriscv RAM between the fetch and load/store ports, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the data port has fixed priority.
module miriscv_mem_arbiter #(
  parameter int          RAM_SIZE  = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         ADDR_W    = $clog2(RAM_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_ack_o,
  output logic              instr_err_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic [31:0]       data_rdata_o,
  output logic              data_ack_o,
  output logic              data_err_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef enum logic {
    PORT_INSTR,
    PORT_DATA
  } port_t;

  // Legal window is [RANGE_LO, RANGE_HI); one extra bit keeps the top bound from wrapping.
  localparam logic [32:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] RANGE_HI = RANGE_LO + 33'(4 * RAM_SIZE);

  state_t      state;
  port_t       winner;
  logic        resp_zero;

  port_t       sel_port;
  logic        any_req;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [29:0] sel_waddr;
  logic [31:0] sel_wdata;
  logic        sel_in_range;
  logic [ADDR_W-1:0] sel_word;

  // Byte offset within a word is irrelevant for whole-word RAM accesses.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  port_t last_grant;
`endif

  assign any_req = instr_req_i | data_req_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_port = PORT_INSTR;
`ifdef ARB_ROUND_ROBIN_EN
    if (instr_req_i && data_req_i) begin
      sel_port = (last_grant == PORT_DATA) ? PORT_INSTR : PORT_DATA;
    end else if (data_req_i) begin
      sel_port = PORT_DATA;
    end
`else
    if (data_req_i) begin
      sel_port = PORT_DATA;
    end
`endif
  end

  // The fetch port is always a full-word read.
  always_comb begin
    sel_we    = 1'b0;
    sel_be    = 4'hF;
    sel_waddr = instr_addr_i[31:2];
    sel_wdata = 32'h0;
    if (sel_port == PORT_DATA) begin
      sel_we    = data_we_i;
      sel_be    = data_be_i;
      sel_waddr = data_addr_i[31:2];
      sel_wdata = data_wdata_i;
    end
  end

  assign sel_in_range = ({1'b0, sel_waddr, 2'b00} >= RANGE_LO) &&
                        ({1'b0, sel_waddr, 2'b00} <  RANGE_HI);
  assign sel_word     = ADDR_W'(sel_waddr - BASE_ADDR[31:2]);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      winner      <= PORT_INSTR;
      resp_zero   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'h0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'h0;
      instr_ack_o <= 1'b0;
      instr_err_o <= 1'b0;
      data_ack_o  <= 1'b0;
      data_err_o  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            winner    <= sel_port;
            resp_zero <= sel_we | ~sel_in_range;
            if (sel_in_range) begin
              state       <= ST_ACCESS;
              mem_req_o   <= 1'b1;
              mem_we_o    <= sel_we;
              mem_be_o    <= sel_be;
              mem_addr_o  <= sel_word;
              mem_wdata_o <= sel_wdata;
            end else begin
              // Out-of-range requests skip the RAM entirely and answer next cycle.
              state       <= ST_RESP;
              instr_ack_o <= (sel_port == PORT_INSTR);
              instr_err_o <= (sel_port == PORT_INSTR);
              data_ack_o  <= (sel_port == PORT_DATA);
              data_err_o  <= (sel_port == PORT_DATA);
            end
          end
        end

        ST_ACCESS: begin
          state       <= ST_RESP;
          mem_req_o   <= 1'b0;
          mem_we_o    <= 1'b0;
          mem_be_o    <= 4'h0;
          mem_addr_o  <= '0;
          mem_wdata_o <= 32'h0;
          instr_ack_o <= (winner == PORT_INSTR);
          data_ack_o  <= (winner == PORT_DATA);
        end

        ST_RESP: begin
          state       <= ST_IDLE;
          resp_zero   <= 1'b0;
          instr_ack_o <= 1'b0;
          instr_err_o <= 1'b0;
          data_ack_o  <= 1'b0;
          data_err_o  <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= PORT_INSTR;
    end else if (state == ST_IDLE && any_req) begin
      last_grant <= sel_port;
    end
  end
`endif

  // RAM data arrives during the ack cycle, so read data is steered straight through.
  assign instr_rdata_o = (instr_ack_o && !resp_zero) ? mem_rdata_i : 32'h0;
  assign data_rdata_o  = (data_ack_o  && !resp_zero) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter: vector table of single transactions plus hand-written
// sequences for contention, reset mid-access and a request dropped after grant.
module tb_miriscv_mem_arbiter;

  localparam int RAM_SIZE = 512;
  localparam int ADDR_W   = 9;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              instr_req_i;
  logic [31:0]       instr_addr_i;
  logic [31:0]       instr_rdata_o;
  logic              instr_ack_o;
  logic              instr_err_o;
  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [31:0]       data_addr_i;
  logic [31:0]       data_wdata_i;
  logic [31:0]       data_rdata_o;
  logic              data_ack_o;
  logic              data_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  logic              ram_load;
  logic [31:0]       ram [RAM_SIZE];

  int n_checks = 0;
  int n_pass   = 0;

  miriscv_mem_arbiter #(.RAM_SIZE(RAM_SIZE), .BASE_ADDR(32'h0)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_req_i  (instr_req_i),
    .instr_addr_i (instr_addr_i),
    .instr_rdata_o(instr_rdata_o),
    .instr_ack_o  (instr_ack_o),
    .instr_err_o  (instr_err_o),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .data_ack_o   (data_ack_o),
    .data_err_o   (data_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: synchronous read, byte-enabled write, data valid the cycle after the strobe.
  always @(posedge clk_i) begin
    if (ram_load) begin
      for (int i = 0; i < RAM_SIZE; i++) ram[i] <= 32'h0;
      ram[4]      <= 32'hDEADBEEF;
      mem_rdata_i <= 32'h0;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= ram[mem_addr_o];
      end
    end
  end

  typedef struct {
    logic              is_data;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              exp_err;
    logic [ADDR_W-1:0] exp_maddr;
    logic [31:0]       exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"},   {31'h0, mem_req_o},   32'h0);
    check({tag, " mem_we"},    {31'h0, mem_we_o},    32'h0);
    check({tag, " mem_be"},    {28'h0, mem_be_o},    32'h0);
    check({tag, " mem_addr"},  32'(mem_addr_o),      32'h0);
    check({tag, " mem_wdata"}, mem_wdata_o,          32'h0);
    check({tag, " acks"},      {30'h0, instr_ack_o, data_ack_o}, 32'h0);
    check({tag, " errs"},      {30'h0, instr_err_o, data_err_o}, 32'h0);
    check({tag, " rdata"},     instr_rdata_o | data_rdata_o,     32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string       tag;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic        ack_w, err_w, ack_l;
    logic [31:0] rdata_w;
    tag    = $sformatf("vec%0d", idx);
    exp_be = v.is_data ? v.be : 4'hF;
    exp_wd = v.is_data ? v.wdata : 32'h0;
    if (v.is_data) begin
      data_req_i = 1'b1; data_we_i = v.we; data_be_i = v.be;
      data_addr_i = v.addr; data_wdata_i = v.wdata;
    end else begin
      instr_req_i = 1'b1; instr_addr_i = v.addr;
    end
    tick();
    if (!v.exp_err) begin
      check({tag, " mem_req"},   {31'h0, mem_req_o}, 32'h1);
      check({tag, " mem_we"},    {31'h0, mem_we_o},  {31'h0, v.is_data & v.we});
      check({tag, " mem_be"},    {28'h0, mem_be_o},  {28'h0, exp_be});
      check({tag, " mem_addr"},  32'(mem_addr_o),    32'(v.exp_maddr));
      check({tag, " mem_wdata"}, mem_wdata_o,        exp_wd);
      check({tag, " early ack"}, {30'h0, instr_ack_o, data_ack_o}, 32'h0);
      tick();
    end
    ack_w   = v.is_data ? data_ack_o   : instr_ack_o;
    err_w   = v.is_data ? data_err_o   : instr_err_o;
    ack_l   = v.is_data ? instr_ack_o  : data_ack_o;
    rdata_w = v.is_data ? data_rdata_o : instr_rdata_o;
    check({tag, " ack"},       {31'h0, ack_w},     32'h1);
    check({tag, " err"},       {31'h0, err_w},     {31'h0, v.exp_err});
    check({tag, " rdata"},     rdata_w,            v.exp_rdata);
    check({tag, " loser ack"}, {31'h0, ack_l},     32'h0);
    check({tag, " resp mem_req"}, {31'h0, mem_req_o}, 32'h0);
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    tick();
    check({tag, " ack gone"}, {30'h0, instr_ack_o, data_ack_o}, 32'h0);
  endtask

  initial begin
    logic exp_d, exp_i;

    // is_data we be addr wdata | exp_err exp_maddr exp_rdata
    vecs[0]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 9'd4,   32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b1, 4'h3, 32'h0000_0020, 32'h1234ABCD,  1'b0, 9'd8,   32'h0};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 9'd8,   32'h0000ABCD};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0800, 32'h0,         1'b1, 9'd0,   32'h0};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 32'h0000_07FF, 32'hA5A50001,  1'b0, 9'd511, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 32'h0000_07FC, 32'h0,         1'b0, 9'd511, 32'hA5A50001};
    vecs[6]  = '{1'b1, 1'b1, 4'hC, 32'h0000_0010, 32'h11223344,  1'b0, 9'd4,   32'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0013, 32'h0,         1'b0, 9'd4,   32'h1122BEEF};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 9'd0,   32'h0};
    vecs[9]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0804, 32'hFFFFFFFF,  1'b1, 9'd0,   32'h0};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0,         1'b0, 9'd1,   32'h0};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 9'd0,   32'h0};

    rst_i = 1'b1; ram_load = 1'b1;
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    tick();
    tick();
    check_all_zero("reset");
    rst_i = 1'b0; ram_load = 1'b0;
    tick();

    // Both ports request continuously: fixed priority starves fetch, round-robin alternates D,I,D.
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h20;
    instr_req_i = 1'b1; instr_addr_i = 32'h10;
    for (int n = 1; n <= 9; n++) begin
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (n == 2) || (n == 8);
      exp_i = (n == 5);
`else
      exp_d = (n % 3 == 2);
      exp_i = 1'b0;
`endif
      check($sformatf("contend c%0d mem_req", n), {31'h0, mem_req_o}, {31'h0, n % 3 == 1});
      check($sformatf("contend c%0d data_ack", n), {31'h0, data_ack_o}, {31'h0, exp_d});
      check($sformatf("contend c%0d instr_ack", n), {31'h0, instr_ack_o}, {31'h0, exp_i});
    end
    data_req_i = 1'b0; instr_req_i = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset during ACCESS drops the access; the still-held request is then served afresh.
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h10;
    tick();
    check("rst seq access", {31'h0, mem_req_o}, 32'h1);
    rst_i = 1'b1;
    tick();
    check_all_zero("rst seq after reset");
    rst_i = 1'b0;
    tick();
    check("rst seq regrant", {31'h0, mem_req_o}, 32'h1);
    check("rst seq no ack", {31'h0, data_ack_o}, 32'h0);
    tick();
    check("rst seq ack", {31'h0, data_ack_o}, 32'h1);
    check("rst seq rdata", data_rdata_o, 32'h1122BEEF);
    data_req_i = 1'b0;
    tick();
    check("rst seq ack gone", {31'h0, data_ack_o}, 32'h0);

    // Fetch request withdrawn (and address changed) right after grant still completes once.
    instr_req_i = 1'b1; instr_addr_i = 32'h7FC;
    tick();
    check("drop seq mem_addr", 32'(mem_addr_o), 32'd511);
    instr_req_i = 1'b0; instr_addr_i = 32'h10;
    tick();
    check("drop seq ack", {31'h0, instr_ack_o}, 32'h1);
    check("drop seq rdata", instr_rdata_o, 32'hA5A50001);
    tick();
    check("drop seq ack once", {31'h0, instr_ack_o}, 32'h0);
    tick();
    check("drop seq idle", {30'h0, mem_req_o, instr_ack_o}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
